// File: rtl/pam4_rgb_rx_checker.sv
// ============================================================================
// Module   : pam4_rgb_rx_checker
// Purpose  : Receive side of the PAM4 RGB link. Decodes sampled 3-bit RGB
//            thermometer codes into 2-bit PAM4 symbols, self-synchronises to
//            the PRBS7 (x^7+x^6+1) stream and counts bit errors for BER
//            measurement. Runs in the symbol clock domain.
// Optional : define PAM4_RX_LOCK_LOSS_CNT_EN to count LOCKED->HUNT
//            transitions on lock_loss_count (tied to 0 otherwise).
// Ports    : clk, rst (async, active-high)
//            data_in[2:0] {R,G,B} sample, data_valid qualifier
//            clear_counters  single-cycle clear of bit/err (and loss) counters
//            symbol_out[1:0], symbol_valid, code_err  decode stage outputs
//            locked, bit_count, err_count, lock_loss_count  checker status
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pam4_rgb_rx_checker #(
  parameter int INV_PATTERN = 1,
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_WINDOW = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           data_in,
  input  logic                 data_valid,
  input  logic                 clear_counters,
  output logic [1:0]           symbol_out,
  output logic                 symbol_valid,
  output logic                 code_err,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [7:0]           lock_loss_count
);

  localparam logic INV_BIT = (INV_PATTERN != 0);
  localparam int   WIN_W   = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  // Accumulator must hold up to LOSS_THRESH+1 (THRESH-1 stored plus 2 new).
  localparam int   THR_W   = $clog2(LOSS_THRESH + 2);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // ---------------- stage 1: thermometer decode ----------------
  logic [1:0] sym_d, sym_q;
  logic       sym_valid_d, sym_valid_q;
  logic       code_err_d, code_err_q;
  logic [1:0] popcnt;
  logic       legal;

  always_comb begin
    popcnt      = {1'b0, data_in[2]} + {1'b0, data_in[1]} + {1'b0, data_in[0]};
    legal       = (data_in == 3'b000) || (data_in == 3'b001) ||
                  (data_in == 3'b011) || (data_in == 3'b111);
    sym_d       = data_valid ? popcnt : sym_q;
    sym_valid_d = data_valid;
    code_err_d  = data_valid & ~legal;
  end

  // ---------------- stage 2: PRBS checker ----------------
  state_t               state_d, state_q;
  logic [6:0]           hist_d, hist_q;   // [0] = newest received bit
  logic [2:0]           fill_d, fill_q;   // bits held in history, sticks at 7
  logic [7:0]           run_d, run_q;
  logic [6:0]           lfsr_d, lfsr_q;   // [0] = newest expected bit
  logic [WIN_W-1:0]     win_cnt_d, win_cnt_q;
  logic [THR_W-1:0]     win_err_d, win_err_q;
  logic [CNT_WIDTH-1:0] bit_cnt_d, bit_cnt_q;
  logic [CNT_WIDTH-1:0] err_cnt_d, err_cnt_q;
  logic                 loss_evt;

  logic                 rx_e, rx_l, exp_e, exp_l, hunt_ok;
  logic [6:0]           hist_next;
  logic [1:0]           nerr;
  logic [THR_W-1:0]     win_sum;
  logic [CNT_WIDTH:0]   bit_sum, err_sum;

  always_comb begin
    // Earlier bit is symbol bit[1]; undo the transmit-side inversion.
    rx_e      = sym_q[1] ^ INV_BIT;
    rx_l      = sym_q[0] ^ INV_BIT;
    hist_next = {hist_q[4:0], rx_e, rx_l};
    // Late-bit prediction uses hist[5]^hist[4], which is the recurrence
    // applied after the early bit of the same symbol has been shifted in.
    hunt_ok   = (rx_e == (hist_q[6] ^ hist_q[5])) &&
                (rx_l == (hist_q[5] ^ hist_q[4]));
    exp_e     = lfsr_q[6] ^ lfsr_q[5];
    exp_l     = lfsr_q[5] ^ lfsr_q[4];
    nerr      = {1'b0, exp_e ^ rx_e} + {1'b0, exp_l ^ rx_l};
    win_sum   = win_err_q + THR_W'(nerr);
    bit_sum   = {1'b0, bit_cnt_q} + (CNT_WIDTH+1)'(2);
    err_sum   = {1'b0, err_cnt_q} + (CNT_WIDTH+1)'(nerr);

    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    run_d     = run_q;
    lfsr_d    = lfsr_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    loss_evt  = 1'b0;

    if (sym_valid_q) begin
      case (state_q)
        ST_HUNT: begin
          hist_d = hist_next;
          fill_d = (fill_q >= 3'd5) ? 3'd7 : fill_q + 3'd2;
          if (fill_q == 3'd7) begin
            if (hunt_ok) begin
              run_d = run_q + 8'd1;
              if (run_q + 8'd1 == 8'(LOCK_COUNT)) begin
                state_d   = ST_LOCKED;
                lfsr_d    = hist_next;
                run_d     = 8'd0;
                win_cnt_d = '0;
                win_err_d = '0;
              end
            end else begin
              run_d = 8'd0;
            end
          end
        end
        default: begin
          lfsr_d    = {lfsr_q[4:0], exp_e, exp_l};
          bit_cnt_d = bit_sum[CNT_WIDTH] ? '1 : bit_sum[CNT_WIDTH-1:0];
          err_cnt_d = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
          if (win_sum >= THR_W'(LOSS_THRESH)) begin
            state_d   = ST_HUNT;
            fill_d    = 3'd0;
            run_d     = 8'd0;
            win_cnt_d = '0;
            win_err_d = '0;
            loss_evt  = 1'b1;
          end else if (win_cnt_q == WIN_W'(LOSS_WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_sum;
          end
        end
      endcase
    end

    // Clear overrides any increment in the same cycle.
    if (clear_counters) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_q       <= 2'd0;
      sym_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      state_q     <= ST_HUNT;
      hist_q      <= 7'd0;
      fill_q      <= 3'd0;
      run_q       <= 8'd0;
      lfsr_q      <= 7'd0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      code_err_q  <= code_err_d;
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      lfsr_q      <= lfsr_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef PAM4_RX_LOCK_LOSS_CNT_EN
  logic [7:0] llc_d, llc_q;

  always_comb begin
    llc_d = llc_q;
    if (loss_evt && (llc_q != 8'hFF)) llc_d = llc_q + 8'd1;
    if (clear_counters) llc_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) llc_q <= 8'd0;
    else     llc_q <= llc_d;
  end

  assign lock_loss_count = llc_q;
`else
  logic unused_loss;
  assign unused_loss     = loss_evt;
  assign lock_loss_count = 8'd0;
`endif

  assign symbol_out   = sym_q;
  assign symbol_valid = sym_valid_q;
  assign code_err     = code_err_q;
  assign locked       = (state_q == ST_LOCKED);
  assign bit_count    = bit_cnt_q;
  assign err_count    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pam4_rgb_rx_checker.sv
// ============================================================================
// Module   : tb_pam4_rgb_rx_checker
// Purpose  : Self-checking bench for pam4_rgb_rx_checker. A PRBS7 source
//            drives thermometer codes with random gaps, bit flips and
//            clears; a behavioural model tracks the expected outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pam4_rgb_rx_checker;

  localparam int  INV     = 1;
  localparam int  LOCK    = 16;
  localparam int  WIN     = 64;
  localparam int  THRESH  = 8;
  localparam int  CW      = 12;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    data_in = 3'd0;
  logic          data_valid = 1'b0;
  logic          clear_counters = 1'b0;
  logic [1:0]    symbol_out;
  logic          symbol_valid;
  logic          code_err;
  logic          locked;
  logic [CW-1:0] bit_count;
  logic [CW-1:0] err_count;
  logic [7:0]    lock_loss_count;

  pam4_rgb_rx_checker #(
    .INV_PATTERN (INV),
    .LOCK_COUNT  (LOCK),
    .LOSS_WINDOW (WIN),
    .LOSS_THRESH (THRESH),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .clear_counters  (clear_counters),
    .symbol_out      (symbol_out),
    .symbol_valid    (symbol_valid),
    .code_err        (code_err),
    .locked          (locked),
    .bit_count       (bit_count),
    .err_count       (err_count),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit     m_locked;
  bit     rxq[$];      // received bits since entering HUNT (oldest first)
  bit     expq[$];     // last 7 expected bits while locked (oldest first)
  int     m_run, m_win_n, m_win_e, m_llc;
  longint m_bitc, m_errc;
  bit       p_valid;
  bit [2:0] p_data;

  function automatic int ones3(input bit [2:0] d);
    return int'(d[0]) + int'(d[1]) + int'(d[2]);
  endfunction

  function automatic bit is_legal(input bit [2:0] d);
    return (d == 3'b000) || (d == 3'b001) || (d == 3'b011) || (d == 3'b111);
  endfunction

  task automatic model_reset();
    m_locked = 0; rxq.delete(); expq.delete();
    m_run = 0; m_win_n = 0; m_win_e = 0; m_llc = 0;
    m_bitc = 0; m_errc = 0; p_valid = 0; p_data = 0;
  endtask

  task automatic model_proc(input bit v, input bit [2:0] d, input bit clr);
    int  sym, n, nm;
    bit  e, l, ee, le, ok;
    if (v) begin
      sym = ones3(d);
      e = bit'((sym >> 1) & 1) ^ bit'(INV);
      l = bit'(sym & 1) ^ bit'(INV);
      if (!m_locked) begin
        n = rxq.size();
        rxq.push_back(e);
        rxq.push_back(l);
        if (n >= 7) begin
          ok = (rxq[n] == (rxq[n-7] ^ rxq[n-6])) &&
               (rxq[n+1] == (rxq[n-6] ^ rxq[n-5]));
          m_run = ok ? m_run + 1 : 0;
          if (m_run == LOCK) begin
            m_locked = 1; m_run = 0; m_win_n = 0; m_win_e = 0;
            expq.delete();
            for (int i = rxq.size() - 7; i < rxq.size(); i++) expq.push_back(rxq[i]);
          end
        end
        while (rxq.size() > 9) void'(rxq.pop_front());
      end else begin
        ee = expq[0] ^ expq[1];
        le = expq[1] ^ expq[2];
        expq.push_back(ee);
        expq.push_back(le);
        void'(expq.pop_front());
        void'(expq.pop_front());
        nm = int'(e != ee) + int'(l != le);
        m_bitc = (m_bitc + 2 > CMAX) ? CMAX : m_bitc + 2;
        m_errc = (m_errc + nm > CMAX) ? CMAX : m_errc + nm;
        m_win_e += nm;
        if (m_win_e >= THRESH) begin
          m_locked = 0; rxq.delete(); m_run = 0; m_win_n = 0; m_win_e = 0;
          if (m_llc < 255) m_llc++;
        end else if (m_win_n == WIN - 1) begin
          m_win_n = 0; m_win_e = 0;
        end else begin
          m_win_n++;
        end
      end
    end
    if (clr) begin m_bitc = 0; m_errc = 0; m_llc = 0; end
  endtask

  function automatic longint exp_llc();
`ifdef PAM4_RX_LOCK_LOSS_CNT_EN
    return m_llc;
`else
    return 0;
`endif
  endfunction

  // ---------------- stimulus ----------------
  bit [6:0] gen = 7'h7F;

  function automatic bit gen_bit();
    bit nb;
    nb  = gen[6] ^ gen[5];
    gen = {gen[5:0], nb};
    return nb;
  endfunction

  function automatic bit [2:0] next_code();
    bit b1, b0;
    bit [1:0] s;
    b1 = gen_bit() ^ bit'(INV);
    b0 = gen_bit() ^ bit'(INV);
    s  = {b1, b0};
    case (s)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  task automatic step(input bit v, input bit [2:0] d, input bit clr);
    data_valid = v; data_in = d; clear_counters = clr;
    @(posedge clk); #1;
    model_proc(p_valid, p_data, clr);
    check_eq("symbol_valid", symbol_valid, v);
    if (v) begin
      check_eq("symbol_out", symbol_out, ones3(d));
      check_eq("code_err", code_err, !is_legal(d));
    end else begin
      check_eq("code_err_idle", code_err, 0);
    end
    check_eq("locked", locked, m_locked);
    check_eq("bit_count", bit_count, m_bitc);
    check_eq("err_count", err_count, m_errc);
    check_eq("lock_loss_count", lock_loss_count, exp_llc());
    p_valid = v; p_data = d;
    data_valid = 1'b0; clear_counters = 1'b0;
  endtask

  task automatic send(input int n, input int pv, input int perr, input int pclr);
    bit [2:0] d;
    bit v, c;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(99) < pv);
      c = ($urandom_range(99) < pclr);
      if (v) begin
        d = next_code();
        if ($urandom_range(99) < perr) d = d ^ (3'b001 << $urandom_range(2));
      end else begin
        d = 3'($urandom);
      end
      step(v, d, c);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_sym"},    symbol_out, 0);
    check_eq({tag, "_valid"},  symbol_valid, 0);
    check_eq({tag, "_cerr"},   code_err, 0);
    check_eq({tag, "_locked"}, locked, 0);
    check_eq({tag, "_bitc"},   bit_count, 0);
    check_eq({tag, "_errc"},   err_count, 0);
    check_eq({tag, "_llc"},    lock_loss_count, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1; data_valid = 1'b0; clear_counters = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    model_reset();
  endtask

  bit [2:0] dec_in  [6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b010, 3'b101};
  int       dec_exp [6] = '{0, 1, 2, 3, 1, 2};

  initial begin
    bit [2:0] d;
    int guard;
    model_reset();
    reset_dut();

    // Decode legality table.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, dec_in[i], 1'b0);
      check_eq("dec_tbl_sym", symbol_out, dec_exp[i]);
      check_eq("dec_tbl_err", code_err, (i >= 4));
    end
    gen = 7'h7F;
    reset_dut();

    // Clean continuous stream: lock then 1000 symbols.
    send(1020, 100, 0, 0);
    check_eq("clean_locked", locked, 1);
    check_eq("clean_errc", err_count, 0);

    // Five separate single-bit flips while locked.
    for (int k = 0; k < 5; k++) begin
      send(15, 100, 0, 0);
      d = next_code() ^ 3'b001;
      step(1'b1, d, 1'b0);
    end
    send(3, 100, 0, 0);
    check_eq("inj_locked", locked, 1);

    // R-bit flip turning 011 into 111.
    guard = 0;
    d = next_code();
    while (d != 3'b011 && guard < 200) begin
      step(1'b1, d, 1'b0);
      d = next_code();
      guard++;
    end
    check_eq("find_011", (guard < 200), 1);
    step(1'b1, d ^ 3'b100, 1'b0);
    send(3, 100, 0, 0);

    // Loss of lock: 8 errored symbols within a window, then relock.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, next_code() ^ 3'b001, 1'b0);
      send(1, 100, 0, 0);
    end
    check_eq("loss_unlocked", locked, 0);
    send(80, 100, 0, 0);
    check_eq("relocked", locked, 1);

    // Gapped valid while locked.
    send(400, 50, 0, 0);

    // Clear coincident with an error symbol in the checker stage.
    step(1'b1, next_code() ^ 3'b010, 1'b0);
    step(1'b1, next_code(), 1'b1);
    check_eq("clr_bitc", bit_count, 0);
    check_eq("clr_errc", err_count, 0);

    // Saturation of bit_count.
    send(2200, 100, 0, 0);
    check_eq("sat_bitc", bit_count, CMAX);
    step(1'b0, 3'd0, 1'b1);

    // Random mix of gaps, errors and clears.
    send(3000, 80, 3, 1);

    // Asynchronous reset mid-lock.
    send(120, 100, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_eq("post_rst_locked", locked, 0);
    send(60, 100, 0, 0);
    check_eq("post_rst_relock", locked, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
